uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised UART receiver: the successor to the fixed 8N1 receiver. It adds configurable baud, data width, parity and stop bits, 3-sample majority voting, false-start rejection, parity/framing error reporting and a small output FIFO with a valid/ready interface. It sits between the board RX pin and any byte consumer, such as a loopback or command parser.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- BAUD, 9600: line rate in baud.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits, legal 1 or 2.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, ≥2.
- sys_clk  in  1  clock.
- sys_rst  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  asynchronous serial line, idle high.
- m_data  out  DATA_BITS  received word, LSB = first bit on the line.
- m_parity_err  out  1  parity mismatch for the word on m_data (0 when PARITY=0).
- m_frame_err  out  1  a stop bit was sampled low for the word on m_data.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts; a pop occurs when m_valid && m_ready.
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- busy  out  1  FSM not in IDLE.

## Operation
- uart_rx passes through a 2-flop synchroniser; both flops reset to 1. All sampling uses the synchronised line `rxs`.
- DIV = (CLK_FREQ + BAUD/2) / BAUD. MID = DIV/2. The baud counter is clog2(DIV) bits wide, counts 0..DIV-1 and wraps.
- Bit value = majority of rxs at counter values MID-1, MID and MID+1. The bit is decided at MID+1 ("sample point").
- Arming: after reset, the receiver ignores the line until rxs has been high for DIV consecutive cycles. A line held low across reset release therefore produces no frame.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP (repeated STOP_BITS times) → IDLE.
- IDLE: armed and rxs falls 1→0 → START, counter cleared.
- START: a sample point of 1 is a false start → IDLE, nothing pushed. Otherwise at counter DIV-1 → DATA.
- DATA: shift LSB first, DATA_BITS samples. Then go to PARITY or STOP.
- PARITY: received bit XOR data is compared against the mode; a mismatch sets parity_err.
- STOP: a sample of 0 sets frame_err. At the sample point of the last stop bit:
  - push {frame_err, parity_err, data} into the FIFO;
  - go to IDLE immediately, without waiting for the end of the bit, so back-to-back frames are not missed.
- Frames with errors are still pushed, with the flags set.
- FIFO behaviour:
  - Push when full and no pop in the same cycle: the frame is dropped, overrun pulses once, and stored entries are unchanged.
  - Push and pop in the same cycle when full: both happen, no overrun.
  - Pop when empty: ignored.
  - The read pointer wraps modulo FIFO_DEPTH.
- m_data and the error flags hold stable while m_valid && !m_ready.

## Timing
- Reset values: m_data = 0, m_parity_err = 0, m_frame_err = 0, m_valid = 0, overrun = 0, busy = 0. The FSM returns to IDLE, the FIFO is emptied and the arming counter is cleared.
- Reset mid-frame: the partial frame is discarded and re-arming is required.
- Pin-to-rxs latency: 2 cycles.
- The push happens on the cycle of the last stop-bit sample point. m_valid (or the new head word) is visible on the next cycle.
- Overrun asserts on the same cycle as the rejected push.
- Counting from the first cycle rxs = 0, the push occurs (1 + DATA_BITS + P + STOP_BITS − 1)·DIV + MID + 1 cycles later, where P = 1 when PARITY ≠ 0, else 0.
- A new start edge is accepted from the cycle after the push.
- Throughput: one frame per frame time, sustained, when m_ready = 1.

## Structure
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FSM state encoding;
  - functions uart_div(clk, baud) and clog2.
- Sub-module uart_rx_fifo: a synchronous FIFO, width DATA_BITS+2, depth FIFO_DEPTH, with push/pop/full/empty and a registered output.
- The receiver FSM, synchroniser, majority voter and arming logic stay in uart_rx_core.

## Test plan
- 8N1, CLK_FREQ 50 MHz, BAUD 115200 (DIV = 434), send 0x55, m_ready = 1 → m_data = 0x55, both flags 0, m_valid high for exactly 1 cycle, timed per the formula.
- PARITY = 2, send 0xA3 with a wrong parity bit → m_data = 0xA3, m_parity_err = 1. Repeat with correct parity → m_parity_err = 0.
- 8N2, second stop bit driven low → m_frame_err = 1, data correct. The next frame sent back-to-back is received correctly.
- Glitch: uart_rx low for 100 cycles (< MID) → no push, busy returns to 0, FIFO empty.
- m_ready = 0, send 5 frames 0x01..0x05 with FIFO_DEPTH = 4 → one overrun pulse on the 5th frame. Popping then yields 0x01..0x04 in order, then m_valid = 0.
- Assert sys_rst mid-frame while the line is low, release with the line still low → no output. After the line idles high ≥ DIV cycles, a frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - parity mode encodings used by the PARITY parameter
//   - receiver FSM state encoding
//   - uart_div(): clocks per bit, rounded to nearest
//   - clog2(): ceiling log2 with a floor of 1, for counter and pointer widths
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding received words {frame_err, parity_err, data}.
// The head entry is presented on rdata_o straight from the storage flops, so it
// stays stable until popped.
//
// Ports:
//   sys_clk  - clock
//   sys_rst  - asynchronous active-low reset; empties the FIFO, clears storage
//   push_i   - write request; ignored when full unless a pop happens as well
//   wdata_i  - word to write
//   pop_i    - read request; ignored when empty
//   rdata_o  - head word (zero after reset)
//   full_o   - all DEPTH entries occupied
//   empty_o  - no entries
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Parametrised UART receiver: 2-flop synchroniser, arming on a quiet line,
// 3-sample majority voting around mid-bit, false-start rejection, optional
// odd/even parity, 1 or 2 stop bits, and an output FIFO with valid/ready.
//
// Ports:
//   sys_clk      - clock, CLK_FREQ Hz
//   sys_rst      - asynchronous active-low reset
//   uart_rx      - asynchronous serial input, idle high
//   m_data       - head received word, LSB is the first bit on the line
//   m_parity_err - parity mismatch for the word on m_data
//   m_frame_err  - a stop bit of that word was sampled low
//   m_valid      - FIFO not empty
//   m_ready      - consumer accepts; pop when m_valid && m_ready
//   overrun      - pulses in the cycle a completed frame is dropped (FIFO full)
//   busy         - receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned MID = DIV / 2;
    localparam int unsigned CW  = clog2(DIV);
    localparam int unsigned AW  = clog2(DIV + 1);
    localparam int unsigned BCW = clog2(DATA_BITS);
    localparam int unsigned WW  = DATA_BITS + 2;

    localparam logic [CW-1:0]  CNT_MID_M1 = CW'(MID - 1);
    localparam logic [CW-1:0]  CNT_MID    = CW'(MID);
    localparam logic [CW-1:0]  CNT_SMP    = CW'(MID + 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
    localparam logic [AW-1:0]  ARM_FULL   = AW'(DIV);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);
    localparam logic           STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic           HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic           ODD_MODE   = (PARITY == PAR_ODD);

    // Synchroniser and line history
    logic [1:0]           sync_q;
    logic                 rxs;
    logic                 rxs_prev_q;

    // Arming
    logic [AW-1:0]        arm_cnt_q, arm_cnt_d;
    logic                 armed;
    logic                 start_edge;

    // FSM and datapath
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;

    logic                 at_smp;
    logic                 at_last;
    logic                 last_stop;
    logic                 maj;

    // FIFO interface
    logic                 push;
    logic [WW-1:0]        push_word;
    logic [WW-1:0]        head_word;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    assign rxs        = sync_q[1];
    assign armed      = (arm_cnt_q == ARM_FULL);
    assign start_edge = armed & rxs_prev_q & ~rxs;

    assign at_smp    = (cnt_q == CNT_SMP);
    assign at_last   = (cnt_q == CNT_LAST);
    assign last_stop = (stop_cnt_q == STOP_LAST);

    // Decision uses the two stored samples plus the live sample at MID+1.
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

    // -------------------------------------------------------------------------
    // Synchroniser, arming and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            arm_cnt_q  <= '0;
            cnt_q      <= '0;
            smp_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rxs_prev_q <= rxs;
            arm_cnt_q  <= arm_cnt_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Arming: count consecutive high cycles of rxs; once DIV is reached the
    // receiver stays armed until the next reset.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = rxs ? (arm_cnt_q + AW'(1)) : '0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = at_last ? '0 : (cnt_q + CW'(1));
        smp_d      = smp_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;

        if (cnt_q == CNT_MID_M1) begin
            smp_d[0] = rxs;
        end
        if (cnt_q == CNT_MID) begin
            smp_d[1] = rxs;
        end

        case (state_q)
            StIdle: begin
                // The edge cycle itself counts as bit-time 0.
                cnt_d = '0;
                if (start_edge) begin
                    state_d    = StStart;
                    cnt_d      = CW'(1);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            StStart: begin
                if (at_smp && maj) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (at_last) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_smp) begin
                    data_d = {maj, data_q[DATA_BITS-1:1]};
                end
                if (at_last) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = HAS_PARITY ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            StParity: begin
                // Odd mode expects odd total ones across data and parity bit.
                if (at_smp && ((maj ^ (^data_q)) != ODD_MODE)) begin
                    par_err_d = 1'b1;
                end
                if (at_last) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (at_smp) begin
                    if (!maj) begin
                        frm_err_d = 1'b1;
                    end
                    // Leave at the last sample point so a following start
                    // edge right at the bit boundary is caught.
                    if (last_stop) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else if (at_last) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q != StIdle);
        push = (state_q == StStop) && at_smp && last_stop;
    end

    // The live stop sample is folded in since frm_err_q has not seen it yet.
    assign push_word = {frm_err_q | ~maj, par_err_q, data_q};

    assign pop     = ~fifo_empty & m_ready;
    assign m_valid = ~fifo_empty;
    assign overrun = push & fifo_full & ~pop;

    uart_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_frame_err  = head_word[WW-1];
    assign m_parity_err = head_word[WW-2];
    assign m_data       = head_word[DATA_BITS-1:0];

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Three receivers share one clock and reset:
//   u_dut0: 8N1 at 115200 baud from 50 MHz (DIV = 434, MID = 217)
//   u_dut1: 8E1 at DIV = 16
//   u_dut2: 8N2 at DIV = 16
// Popped words are captured at the falling edge as {frame_err, parity_err, data}.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst;
    logic       rx  [3];
    logic       rdy [3];

    logic [7:0] d0, d1, d2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       v0, v1, v2;
    logic       ov0, ov1, ov2;
    logic       bz0, bz1, bz2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];
    int         pop_cyc0 [$];
    int         vcnt0  = 0;
    int         ovcnt0 = 0;
    int         ov_cyc0 = 0;

    uart_rx_core #(
        .CLK_FREQ (50_000_000), .BAUD (115_200), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut0 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .uart_rx (rx[0]),
        .m_data (d0), .m_parity_err (pe0), .m_frame_err (fe0), .m_valid (v0),
        .m_ready (rdy[0]), .overrun (ov0), .busy (bz0)
    );

    uart_rx_core #(
        .CLK_FREQ (50_000_000), .BAUD (3_125_000), .DATA_BITS (8),
        .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_dut1 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .uart_rx (rx[1]),
        .m_data (d1), .m_parity_err (pe1), .m_frame_err (fe1), .m_valid (v1),
        .m_ready (rdy[1]), .overrun (ov1), .busy (bz1)
    );

    uart_rx_core #(
        .CLK_FREQ (50_000_000), .BAUD (3_125_000), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_dut2 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .uart_rx (rx[2]),
        .m_data (d2), .m_parity_err (pe2), .m_frame_err (fe2), .m_valid (v2),
        .m_ready (rdy[2]), .overrun (ov2), .busy (bz2)
    );

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (v0 && rdy[0]) begin
            q0.push_back({fe0, pe0, d0});
            pop_cyc0.push_back(cyc);
        end
        if (v1 && rdy[1]) q1.push_back({fe1, pe1, d1});
        if (v2 && rdy[2]) q2.push_back({fe2, pe2, d2});
        if (v0) vcnt0 <= vcnt0 + 1;
        if (ov0) begin
            ovcnt0  <= ovcnt0 + 1;
            ov_cyc0 <= cyc;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_bit(input int which, input logic val, input int div);
        rx[which] = val;
        wait_cycles(div);
    endtask

    task automatic send_frame(input int which, input int div, input logic [7:0] data,
                              input int par_mode, input logic par_flip, input int nstop,
                              input logic stop2_val);
        logic p;
        drive_bit(which, 1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], div);
        if (par_mode != 0) begin
            p = (par_mode == 1) ? ~(^data) : ^data;
            drive_bit(which, p ^ par_flip, div);
        end
        drive_bit(which, 1'b1, div);
        if (nstop == 2) drive_bit(which, stop2_val, div);
        rx[which] = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            rdy[i] = 1'b1;
        end
        wait_cycles(3);
        checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL rst_data: got %h expected 00", d0); end
        checks++; if (pe0 !== 1'b0) begin failures++; $display("FAIL rst_parity_err: got %b expected 0", pe0); end
        checks++; if (fe0 !== 1'b0) begin failures++; $display("FAIL rst_frame_err: got %b expected 0", fe0); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", v0); end
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b expected 0", ov0); end
        checks++; if (bz0 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bz0); end
        checks++; if ({v1, v2} !== 2'b00) begin failures++; $display("FAIL rst_valid_12: got %b expected 00", {v1, v2}); end
        sys_rst = 1'b1;
        wait_cycles(500);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b expected 0", v0); end
    endtask

    task automatic test_basic_8n1();
        int base  = q0.size();
        int vbase = vcnt0;
        int c0    = cyc;
        send_frame(0, 434, 8'h55, 0, 1'b0, 1, 1'b1);
        wait_cycles(20);
        checks++;
        if (q0.size() != base + 1) begin
            failures++; $display("FAIL basic_count: got %0d words expected 1", q0.size() - base);
        end else begin
            checks++; if (q0[base] !== 10'h055) begin failures++; $display("FAIL basic_word: got %h expected 055", q0[base]); end
            // 2 sync + 9*434 + 218 to the last sample point, +1 for the FIFO
            checks++; if (pop_cyc0[base] - c0 != 4127) begin failures++; $display("FAIL basic_latency: got %0d expected 4127", pop_cyc0[base] - c0); end
        end
        checks++; if (vcnt0 - vbase != 1) begin failures++; $display("FAIL basic_valid_width: got %0d expected 1", vcnt0 - vbase); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL basic_valid_after: got %b expected 0", v0); end
    endtask

    task automatic test_parity();
        int base = q1.size();
        send_frame(1, 16, 8'hA3, 2, 1'b1, 1, 1'b1);
        send_frame(1, 16, 8'hA3, 2, 1'b0, 1, 1'b1);
        wait_cycles(10);
        checks++;
        if (q1.size() != base + 2) begin
            failures++; $display("FAIL parity_count: got %0d words expected 2", q1.size() - base);
        end else begin
            checks++; if (q1[base] !== 10'h1A3) begin failures++; $display("FAIL parity_bad: got %h expected 1a3", q1[base]); end
            checks++; if (q1[base + 1] !== 10'h0A3) begin failures++; $display("FAIL parity_good: got %h expected 0a3", q1[base + 1]); end
        end
    endtask

    task automatic test_frame_err_8n2();
        int base = q2.size();
        send_frame(2, 16, 8'h3C, 0, 1'b0, 2, 1'b0);
        drive_bit(2, 1'b1, 16);
        send_frame(2, 16, 8'h96, 0, 1'b0, 2, 1'b1);
        send_frame(2, 16, 8'h5A, 0, 1'b0, 2, 1'b1);
        wait_cycles(10);
        checks++;
        if (q2.size() != base + 3) begin
            failures++; $display("FAIL frame_count: got %0d words expected 3", q2.size() - base);
        end else begin
            checks++; if (q2[base] !== 10'h23C) begin failures++; $display("FAIL frame_err_word: got %h expected 23c", q2[base]); end
            checks++; if (q2[base + 1] !== 10'h096) begin failures++; $display("FAIL b2b_first: got %h expected 096", q2[base + 1]); end
            checks++; if (q2[base + 2] !== 10'h05A) begin failures++; $display("FAIL b2b_second: got %h expected 05a", q2[base + 2]); end
        end
    endtask

    task automatic test_glitch();
        int base = q0.size();
        rx[0] = 1'b0;
        wait_cycles(50);
        checks++; if (bz0 !== 1'b1) begin failures++; $display("FAIL glitch_busy_during: got %b expected 1", bz0); end
        wait_cycles(50);
        rx[0] = 1'b1;
        wait_cycles(400);
        checks++; if (bz0 !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got %b expected 0", bz0); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b expected 0", v0); end
        checks++; if (q0.size() != base) begin failures++; $display("FAIL glitch_words: got %0d expected 0", q0.size() - base); end
    endtask

    task automatic test_overrun();
        int base = q0.size();
        int ovb  = ovcnt0;
        int c0   = cyc;
        logic [7:0] k;
        rdy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            k = 8'(i);
            send_frame(0, 434, k, 0, 1'b0, 1, 1'b1);
        end
        wait_cycles(10);
        checks++; if (ovcnt0 - ovb != 1) begin failures++; $display("FAIL overrun_pulses: got %0d expected 1", ovcnt0 - ovb); end
        // Fifth frame starts 4*4340 cycles in; its push is 4126 cycles later.
        checks++; if (ov_cyc0 - c0 != 21486) begin failures++; $display("FAIL overrun_cycle: got %0d expected 21486", ov_cyc0 - c0); end
        checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL overrun_valid: got %b expected 1", v0); end
        checks++; if (d0 !== 8'h01) begin failures++; $display("FAIL overrun_hold: got %h expected 01", d0); end
        checks++; if (q0.size() != base) begin failures++; $display("FAIL overrun_early_pop: got %0d expected 0", q0.size() - base); end
        rdy[0] = 1'b1;
        wait_cycles(10);
        checks++;
        if (q0.size() != base + 4) begin
            failures++; $display("FAIL overrun_drain_count: got %0d expected 4", q0.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q0[base + i] !== 10'(i + 1)) begin
                    failures++; $display("FAIL overrun_drain_%0d: got %h expected %h", i, q0[base + i], 10'(i + 1));
                end
            end
        end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL overrun_empty: got %b expected 0", v0); end
    endtask

    task automatic test_reset_midframe();
        int base = q0.size();
        rx[0] = 1'b0;
        wait_cycles(1000);
        checks++; if (bz0 !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", bz0); end
        sys_rst = 1'b0;
        #1;
        checks++; if (bz0 !== 1'b0) begin failures++; $display("FAIL midrst_busy_in_reset: got %b expected 0", bz0); end
        wait_cycles(3);
        sys_rst = 1'b1;
        wait_cycles(600);
        checks++; if (bz0 !== 1'b0) begin failures++; $display("FAIL midrst_busy_low_line: got %b expected 0", bz0); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", v0); end
        checks++; if (q0.size() != base) begin failures++; $display("FAIL midrst_words: got %0d expected 0", q0.size() - base); end
        rx[0] = 1'b1;
        wait_cycles(500);
        send_frame(0, 434, 8'hC3, 0, 1'b0, 1, 1'b1);
        wait_cycles(20);
        checks++;
        if (q0.size() != base + 1) begin
            failures++; $display("FAIL midrst_rearm_count: got %0d expected 1", q0.size() - base);
        end else begin
            checks++; if (q0[base] !== 10'h0C3) begin failures++; $display("FAIL midrst_rearm_word: got %h expected 0c3", q0[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_frame_err_8n2();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
